// File: rtl/seq_pkg.sv
// Shared phase encodings for the phase sequencer and the instruction decoder.
// The decoder relies on these exact values, so they must not be renumbered.
package seq_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PH_IDLE = 3'b000;
  localparam logic [PHASE_W-1:0] PH_P1   = 3'b001;
  localparam logic [PHASE_W-1:0] PH_P2   = 3'b010;
  localparam logic [PHASE_W-1:0] PH_P3   = 3'b011;
  localparam logic [PHASE_W-1:0] PH_P4   = 3'b100;
  localparam logic [PHASE_W-1:0] PH_P5   = 3'b101;

  typedef enum logic [PHASE_W-1:0] {
    S_IDLE = PH_IDLE,
    S_P1   = PH_P1,
    S_P2   = PH_P2,
    S_P3   = PH_P3,
    S_P4   = PH_P4,
    S_P5   = PH_P5
  } phase_t;

  // True for the phases in which a stop request is latched rather than acted on.
  function automatic logic mid_instr(input phase_t p);
    return (p == S_P1) || (p == S_P2) || (p == S_P3) || (p == S_P4);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer followed by a rising-edge detector.
// The pulse is formed from flops only, so it is glitch-free; a held button
// yields exactly one pulse. SYNC_STAGES must be at least 2.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the raw button through the synchronizer and remember the last synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with front-panel start/stop and HALT.
// Optional build macro: STEP_MODE_EN adds the step_mode input (one
// instruction per start press).
//
// state  | meaning
// IDLE   | stopped, waiting for a start press
// P1     | fetch
// P2     | decode / register read
// P3     | execute
// P4     | memory; stretched while mem_busy is high
// P5     | writeback; retires the instruction and picks run/stop/halt
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               hlt,
  input  logic               mem_busy,
`ifdef STEP_MODE_EN
  input  logic               step_mode,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               stop_pend,
  output logic [CNT_W-1:0]   retired
);

  phase_t     phase_q, phase_d;
  logic       halted_d, stop_pend_d;
  logic       retire;
  logic       start_ev, stop_ev;
  logic       step_stop;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start_ev)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (stop_btn),
    .pulse (stop_ev)
  );

`ifdef STEP_MODE_EN
  assign step_stop = step_mode;
`else
  assign step_stop = 1'b0;
`endif

  // Next phase, halt/stop flags and retire strobe.
  always_comb begin
    phase_d     = phase_q;
    halted_d    = halted;
    stop_pend_d = stop_pend;
    retire      = 1'b0;

    if (mid_instr(phase_q) && stop_ev) begin
      stop_pend_d = 1'b1;
    end

    case (phase_q)
      S_IDLE: begin
        // start wins over a simultaneous stop; a lone stop in IDLE is dropped
        if (start_ev) begin
          phase_d  = S_P1;
          halted_d = 1'b0;
        end
      end
      S_P1: phase_d = S_P2;
      S_P2: phase_d = S_P3;
      S_P3: phase_d = S_P4;
      S_P4: begin
        if (!mem_busy) begin
          phase_d = S_P5;
        end
      end
      S_P5: begin
        retire      = 1'b1;
        stop_pend_d = 1'b0;
        if (hlt) begin
          phase_d  = S_IDLE;
          halted_d = 1'b1;
        end else if (stop_pend || stop_ev || step_stop) begin
          phase_d = S_IDLE;
        end else begin
          phase_d = S_P1;
        end
      end
      default: begin
        phase_d     = S_IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // State, flags and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= S_IDLE;
      halted    <= 1'b0;
      stop_pend <= 1'b0;
      retired   <= '0;
    end else begin
      phase_q   <= phase_d;
      halted    <= halted_d;
      stop_pend <= stop_pend_d;
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign phase   = phase_q;
  assign running = (phase_q != S_IDLE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (CNT_W=4 so the counter wrap is reachable).
module tb_phase_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_btn = 1'b0;
  logic             stop_btn = 1'b0;
  logic             hlt = 1'b0;
  logic             mem_busy = 1'b0;
`ifdef STEP_MODE_EN
  logic             step_mode = 1'b0;
`endif
  logic [2:0]       phase;
  logic             running;
  logic             halted;
  logic             stop_pend;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int passed = 0;

  phase_sequencer #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .hlt       (hlt),
    .mem_busy  (mem_busy),
`ifdef STEP_MODE_EN
    .step_mode (step_mode),
`endif
    .phase     (phase),
    .running   (running),
    .halted    (halted),
    .stop_pend (stop_pend),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++; if (phase !== 3'b000) $display("FAIL reset_phase got=%b exp=000", phase); else passed++;
    checks++; if (retired !== 4'd0) $display("FAIL reset_retired got=%0d exp=0", retired); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else passed++;
    checks++; if (stop_pend !== 1'b0) $display("FAIL reset_stop_pend got=%b exp=0", stop_pend); else passed++;
  endtask

  task automatic test_start_run;
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b001};
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(2);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1);
      checks++;
      if (phase !== seq[i]) $display("FAIL run_seq[%0d] got=%b exp=%b", i, phase, seq[i]);
      else passed++;
    end
    checks++; if (retired !== 4'd1) $display("FAIL run_retired got=%0d exp=1", retired); else passed++;
    checks++; if (running !== 1'b1) $display("FAIL run_running got=%b exp=1", running); else passed++;
  endtask

  task automatic test_mem_stretch;
    step(2);
    checks++; if (phase !== 3'b011) $display("FAIL mem_p3 got=%b exp=011", phase); else passed++;
    mem_busy = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (phase !== 3'b100) $display("FAIL mem_hold[%0d] got=%b exp=100", i, phase);
      else passed++;
      step(1);
    end
    checks++; if (phase !== 3'b100) $display("FAIL mem_hold[4] got=%b exp=100", phase); else passed++;
    mem_busy = 1'b0;
    step(1);
    checks++; if (phase !== 3'b101) $display("FAIL mem_p5 got=%b exp=101", phase); else passed++;
    checks++; if (retired !== 4'd1) $display("FAIL mem_retired_pre got=%0d exp=1", retired); else passed++;
    step(1);
    checks++; if (phase !== 3'b001) $display("FAIL mem_next got=%b exp=001", phase); else passed++;
    checks++; if (retired !== 4'd2) $display("FAIL mem_retired got=%0d exp=2", retired); else passed++;
  endtask

  task automatic test_stop;
    step(1);
    checks++; if (phase !== 3'b010) $display("FAIL stop_p2 got=%b exp=010", phase); else passed++;
    stop_btn = 1'b1;
    step(1);
    stop_btn = 1'b0;
    step(2);
    checks++; if (phase !== 3'b101) $display("FAIL stop_p5 got=%b exp=101", phase); else passed++;
    checks++; if (stop_pend !== 1'b1) $display("FAIL stop_pend_set got=%b exp=1", stop_pend); else passed++;
    step(1);
    checks++; if (phase !== 3'b000) $display("FAIL stop_idle got=%b exp=000", phase); else passed++;
    checks++; if (stop_pend !== 1'b0) $display("FAIL stop_pend_clr got=%b exp=0", stop_pend); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL stop_halted got=%b exp=0", halted); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL stop_running got=%b exp=0", running); else passed++;
    checks++; if (retired !== 4'd3) $display("FAIL stop_retired got=%0d exp=3", retired); else passed++;
  endtask

  task automatic test_halt;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(3);
    checks++; if (phase !== 3'b010) $display("FAIL halt_p2 got=%b exp=010", phase); else passed++;
    stop_btn = 1'b1;
    step(1);
    stop_btn = 1'b0;
    step(2);
    checks++; if (stop_pend !== 1'b1) $display("FAIL halt_stop_pend got=%b exp=1", stop_pend); else passed++;
    hlt = 1'b1;
    step(1);
    hlt = 1'b0;
    checks++; if (phase !== 3'b000) $display("FAIL halt_idle got=%b exp=000", phase); else passed++;
    checks++; if (halted !== 1'b1) $display("FAIL halt_set got=%b exp=1", halted); else passed++;
    checks++; if (stop_pend !== 1'b0) $display("FAIL halt_stop_clr got=%b exp=0", stop_pend); else passed++;
    checks++; if (retired !== 4'd4) $display("FAIL halt_retired got=%0d exp=4", retired); else passed++;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(1);
    checks++; if (halted !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", halted); else passed++;
    step(1);
    checks++; if (phase !== 3'b001) $display("FAIL halt_restart got=%b exp=001", phase); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL halt_cleared got=%b exp=0", halted); else passed++;
  endtask

  task automatic test_reset_mid;
    step(2);
    checks++; if (phase !== 3'b011) $display("FAIL rstmid_p3 got=%b exp=011", phase); else passed++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (phase !== 3'b000) $display("FAIL rstmid_idle got=%b exp=000", phase); else passed++;
    checks++; if (retired !== 4'd0) $display("FAIL rstmid_retired got=%0d exp=0", retired); else passed++;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(4);
    mem_busy = 1'b1;
    step(3);
    checks++; if (phase !== 3'b100) $display("FAIL rstp4_hold got=%b exp=100", phase); else passed++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mem_busy = 1'b0;
    checks++; if (phase !== 3'b000) $display("FAIL rstp4_idle got=%b exp=000", phase); else passed++;
    checks++; if (retired !== 4'd0) $display("FAIL rstp4_retired got=%0d exp=0", retired); else passed++;
    step(1);
    checks++; if (phase !== 3'b000) $display("FAIL rstp4_stay got=%b exp=000", phase); else passed++;
  endtask

  task automatic test_wrap;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(2);
    step(75);
    checks++; if (phase !== 3'b001) $display("FAIL wrap_p1 got=%b exp=001", phase); else passed++;
    checks++; if (retired !== 4'd15) $display("FAIL wrap_15 got=%0d exp=15", retired); else passed++;
    stop_btn = 1'b1;
    step(1);
    stop_btn = 1'b0;
    step(2);
    checks++; if (stop_pend !== 1'b1) $display("FAIL wrap_stop_pend got=%b exp=1", stop_pend); else passed++;
    step(2);
    checks++; if (phase !== 3'b000) $display("FAIL wrap_idle got=%b exp=000", phase); else passed++;
    checks++; if (retired !== 4'd0) $display("FAIL wrap_zero got=%0d exp=0", retired); else passed++;
    step(3);
    checks++; if (retired !== 4'd0) $display("FAIL wrap_hold got=%0d exp=0", retired); else passed++;
  endtask

  task automatic test_back_to_back;
    stop_btn = 1'b1;
    step(1);
    stop_btn = 1'b0;
    step(2);
    checks++; if (phase !== 3'b000) $display("FAIL idle_stop_phase got=%b exp=000", phase); else passed++;
    checks++; if (stop_pend !== 1'b0) $display("FAIL idle_stop_pend got=%b exp=0", stop_pend); else passed++;
    step(2);
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    step(1);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    step(2);
    checks++; if (phase !== 3'b001) $display("FAIL both_p1 got=%b exp=001", phase); else passed++;
    checks++; if (stop_pend !== 1'b0) $display("FAIL both_stop_pend got=%b exp=0", stop_pend); else passed++;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(2);
    checks++; if (phase !== 3'b100) $display("FAIL run_start_ign got=%b exp=100", phase); else passed++;
    step(2);
    checks++; if (phase !== 3'b001) $display("FAIL run_continue got=%b exp=001", phase); else passed++;
    checks++; if (retired !== 4'd1) $display("FAIL run_continue_ret got=%0d exp=1", retired); else passed++;
    start_btn = 1'b1;
    step(10);
    start_btn = 1'b0;
    checks++; if (phase !== 3'b001) $display("FAIL held_start got=%b exp=001", phase); else passed++;
    checks++; if (retired !== 4'd3) $display("FAIL held_start_ret got=%0d exp=3", retired); else passed++;
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_mem_stretch();
    test_stop();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
